// File: rtl/rv_wb_pkg.sv
// Shared widths and the writeback request type for the register-file write port.
package rv_wb_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    // One writeback request as presented by a requester.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register busy scoreboard: issue sets a bit, the RF write clears it.
// Bit 0 never goes busy because x0 is hard-wired zero.
module wb_scoreboard
    import rv_wb_pkg::*;
#(
    parameter int NUM_REGS = NREG
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_rd,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_rd,
    input  logic [REG_AW-1:0] rd_a,
    input  logic [REG_AW-1:0] rd_b,
    input  logic [REG_AW-1:0] rd_c,
    output logic              busy_a,
    output logic              busy_b,
    output logic              busy_c
);

    logic [NUM_REGS-1:0] busy;

    // Clear first, then set, so a new producer issued on the retire edge keeps the bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            if (clr_en) busy[clr_rd] <= 1'b0;
            if (set_en) busy[set_rd] <= 1'b1;
            busy[0] <= 1'b0;
        end
    end

    assign busy_a = busy[rd_a];
    assign busy_b = busy[rd_b];
    assign busy_c = busy[rd_c];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the ALU (req0) and the
// long-latency load/mul unit (req1), and tracks pending writes for hazard stalls.
module regfile_wb_arbiter
    import rv_wb_pkg::REG_AW;
#(
    parameter int XLEN     = rv_wb_pkg::XLEN,
    parameter int NREG     = rv_wb_pkg::NREG,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [REG_AW-1:0] req0_rd,
    input  logic [XLEN-1:0]   req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [REG_AW-1:0] req1_rd,
    input  logic [XLEN-1:0]   req1_data,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_rd,
    output logic              iss_stall,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              write_en,
    output logic [REG_AW-1:0] A3,
    output logic [XLEN-1:0]   write_data
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    logic [CW-1:0]     starve_cnt;
    logic              starved;
    logic              grant0;
    logic              grant1;
    logic              any_grant;
    logic [REG_AW-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;
    logic              iss_busy;
    logic              iss_nonzero;
    logic              set_en;

    // req0 wins ties until req1 has lost MAX_WAIT times in a row.
    assign starved    = (starve_cnt == MAX_CNT);
    assign grant1     = req1_valid & (~req0_valid | starved);
    assign grant0     = req0_valid & ~grant1;
    assign any_grant  = grant0 | grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign sel_rd     = grant1 ? req1_rd   : req0_rd;
    assign sel_data   = grant1 ? req1_data : req0_data;

    // Count consecutive lost arbitrations of req1; any break in the waiting resets it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!req1_valid || grant1) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Register the granted request toward the RF; writes to x0 are swallowed here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_en   <= 1'b0;
            A3         <= '0;
            write_data <= '0;
        end else begin
            write_en <= any_grant && (sel_rd != '0);
            if (any_grant) begin
                A3         <= sel_rd;
                write_data <= sel_data;
            end
        end
    end

    assign iss_nonzero = (iss_rd != '0);
    assign iss_stall   = iss_valid & iss_busy & iss_nonzero;
    assign set_en      = iss_valid & ~iss_busy & iss_nonzero;

    wb_scoreboard #(
        .NUM_REGS (NREG)
    ) u_scoreboard (
        .clk    (clk),
        .rst_n  (rst_n),
        .set_en (set_en),
        .set_rd (iss_rd),
        .clr_en (write_en),
        .clr_rd (A3),
        .rd_a   (rs1),
        .rd_b   (rs2),
        .rd_c   (iss_rd),
        .busy_a (rs1_busy),
        .busy_b (rs2_busy),
        .busy_c (iss_busy)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus a randomized run against
// a register-level behavioural model of arbitration, write port and scoreboard.
module tb_regfile_wb_arbiter;
    import rv_wb_pkg::*;

    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0_valid, req0_ready;
    logic [REG_AW-1:0] req0_rd;
    logic [XLEN-1:0]   req0_data;
    logic              req1_valid, req1_ready;
    logic [REG_AW-1:0] req1_rd;
    logic [XLEN-1:0]   req1_data;
    logic              iss_valid, iss_stall;
    logic [REG_AW-1:0] iss_rd, rs1, rs2;
    logic              rs1_busy, rs2_busy;
    logic              write_en;
    logic [REG_AW-1:0] A3;
    logic [XLEN-1:0]   write_data;

    int tests  = 0;
    int failed = 0;

    // Reference model state
    bit [NREG-1:0]     m_busy;
    int                m_starve;
    bit                m_wen;
    logic [REG_AW-1:0] m_a3;
    logic [XLEN-1:0]   m_wdata;

    regfile_wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rd(req0_rd), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rd(req1_rd), .req1_data(req1_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_stall(iss_stall),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .write_en(write_en), .A3(A3), .write_data(write_data)
    );

    always #5 clk = ~clk;

    // Model update at each rising edge, from the stated rules.
    always @(posedge clk) begin
        bit g0, g1, iss_ok;
        if (!rst_n) begin
            m_busy = '0; m_starve = 0; m_wen = 0; m_a3 = '0; m_wdata = '0;
        end else begin
            g1 = req1_valid && (!req0_valid || m_starve == MAX_WAIT);
            g0 = req0_valid && !g1;
            iss_ok = iss_valid && iss_rd != 0 && !m_busy[iss_rd];
            if (m_wen) m_busy[m_a3] = 1'b0;
            if (iss_ok) m_busy[iss_rd] = 1'b1;
            if (!req1_valid || g1) m_starve = 0;
            else if (m_starve < MAX_WAIT) m_starve = m_starve + 1;
            if (g0) begin
                m_wen = (req0_rd != 0); m_a3 = req0_rd; m_wdata = req0_data;
            end else if (g1) begin
                m_wen = (req1_rd != 0); m_a3 = req1_rd; m_wdata = req1_data;
            end else begin
                m_wen = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_rd = '0; req0_data = '0;
        req1_valid = 0; req1_rd = '0; req1_data = '0;
        iss_valid = 0; iss_rd = '0; rs1 = '0; rs2 = '0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        req0_valid = 1; req0_rd = 5'd3; req0_data = 32'h11;
        req1_valid = 1; req1_rd = 5'd4; req1_data = 32'h22;
        iss_valid = 1; iss_rd = 5'd6; rs1 = 5'd6; rs2 = 5'd3;
        repeat (3) tick();
        @(negedge clk);
        tests++;
        if (write_en !== 1'b0 || A3 !== 5'd0) begin
            failed++;
            $display("[TB] FAIL reset_write: write_en=%b A3=%0d, expected 0/0", write_en, A3);
        end
        tests++;
        if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
            failed++;
            $display("[TB] FAIL reset_busy: rs1_busy=%b rs2_busy=%b, expected 0/0", rs1_busy, rs2_busy);
        end
        tick();
        idle_inputs();
        rst_n = 1;
    endtask

    task automatic test_single_write();
        tick(); iss_valid = 1; iss_rd = 5'd5;
        @(negedge clk);
        tests++;
        if (iss_stall !== 1'b0) begin failed++; $display("[TB] FAIL single_iss_stall: got %b expected 0", iss_stall); end
        tick(); iss_valid = 0; rs1 = 5'd5;
        req0_valid = 1; req0_rd = 5'd5; req0_data = 32'hDEADBEEF;
        @(negedge clk);
        tests++;
        if (req0_ready !== 1'b1 || rs1_busy !== 1'b1) begin
            failed++; $display("[TB] FAIL single_accept: ready=%b busy=%b expected 1/1", req0_ready, rs1_busy);
        end
        tick(); req0_valid = 0;
        @(negedge clk);
        tests++;
        if (write_en !== 1'b1 || A3 !== 5'd5 || write_data !== 32'hDEADBEEF || rs1_busy !== 1'b1) begin
            failed++;
            $display("[TB] FAIL single_write: we=%b A3=%0d data=%h busy=%b expected 1/5/deadbeef/1",
                     write_en, A3, write_data, rs1_busy);
        end
        tick();
        @(negedge clk);
        tests++;
        if (rs1_busy !== 1'b0 || write_en !== 1'b0) begin
            failed++; $display("[TB] FAIL single_retire: busy=%b we=%b expected 0/0", rs1_busy, write_en);
        end
    endtask

    task automatic test_contention();
        bit exp1;
        tick();
        req0_valid = 1; req0_rd = 5'd1; req0_data = $urandom;
        req1_valid = 1; req1_rd = 5'd2; req1_data = $urandom;
        for (int i = 0; i < 10; i++) begin
            exp1 = (i % 5 == 4);
            @(negedge clk);
            tests++;
            if (req1_ready !== exp1 || req0_ready !== !exp1) begin
                failed++;
                $display("[TB] FAIL contention_grant[%0d]: ready0=%b ready1=%b expected %b/%b",
                         i, req0_ready, req1_ready, !exp1, exp1);
            end
            if (i > 0) begin
                tests++;
                if (A3 !== ((i % 5 == 0) ? 5'd2 : 5'd1)) begin
                    failed++; $display("[TB] FAIL contention_A3[%0d]: got %0d", i, A3);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_x0();
        tick(); req1_valid = 1; req1_rd = 5'd0; req1_data = 32'h1234;
        @(negedge clk);
        tests++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            failed++; $display("[TB] FAIL x0_accept: ready1=%b ready0=%b expected 1/0", req1_ready, req0_ready);
        end
        tick(); req1_valid = 0; iss_valid = 1; iss_rd = 5'd0; rs1 = 5'd0;
        @(negedge clk);
        tests++;
        if (write_en !== 1'b0 || iss_stall !== 1'b0) begin
            failed++; $display("[TB] FAIL x0_write: we=%b stall=%b expected 0/0", write_en, iss_stall);
        end
        tick(); iss_valid = 0;
        @(negedge clk);
        tests++;
        if (rs1_busy !== 1'b0) begin failed++; $display("[TB] FAIL x0_busy: got %b expected 0", rs1_busy); end
    endtask

    task automatic test_hazards();
        tick(); iss_valid = 1; iss_rd = 5'd7; rs1 = 5'd7;
        @(negedge clk);
        tests++;
        if (iss_stall !== 1'b0) begin failed++; $display("[TB] FAIL haz_first_issue: stall=%b expected 0", iss_stall); end
        tick();
        @(negedge clk);
        tests++;
        if (iss_stall !== 1'b1) begin failed++; $display("[TB] FAIL haz_waw_stall: stall=%b expected 1", iss_stall); end
        tick(); iss_valid = 0;
        @(negedge clk);
        tests++;
        if (rs1_busy !== 1'b1) begin failed++; $display("[TB] FAIL haz_still_busy: busy=%b expected 1", rs1_busy); end
        tick(); req0_valid = 1; req0_rd = 5'd7; req0_data = 32'hA5A5_0007;
        tick(); req0_valid = 0;
        tick();
        @(negedge clk);
        tests++;
        if (rs1_busy !== 1'b0) begin failed++; $display("[TB] FAIL haz_retired: busy=%b expected 0", rs1_busy); end
        tick(); req0_valid = 1; req0_data = 32'h5A5A_0007;
        tick(); req0_valid = 0; iss_valid = 1; iss_rd = 5'd7;
        @(negedge clk);
        tests++;
        if (write_en !== 1'b1 || A3 !== 5'd7 || iss_stall !== 1'b0) begin
            failed++; $display("[TB] FAIL haz_same_edge: we=%b A3=%0d stall=%b expected 1/7/0", write_en, A3, iss_stall);
        end
        tick(); iss_valid = 0;
        @(negedge clk);
        tests++;
        if (rs1_busy !== 1'b1) begin failed++; $display("[TB] FAIL haz_set_wins: busy=%b expected 1", rs1_busy); end
    endtask

    task automatic test_reset_midop();
        tick(); iss_valid = 1; iss_rd = 5'd9;
        tick(); iss_valid = 0; req0_valid = 1; req0_rd = 5'd9; req0_data = 32'hCAFE_0009; rst_n = 0;
        @(negedge clk);
        tests++;
        if (req0_ready !== 1'b1) begin failed++; $display("[TB] FAIL midop_accept: ready=%b expected 1", req0_ready); end
        tick(); rst_n = 1; req0_valid = 0; rs1 = 5'd9; rs2 = 5'd7;
        @(negedge clk);
        tests++;
        if (write_en !== 1'b0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
            failed++; $display("[TB] FAIL midop_drop: we=%b busy9=%b busy7=%b expected 0/0/0", write_en, rs1_busy, rs2_busy);
        end
    endtask

    task automatic test_random();
        bit seen0 = 0, seen1 = 0, e0, e1, es;
        wb_req_t p0, p1;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (!req0_valid || seen0) begin
                p0.rd = REG_AW'($urandom_range(0, 7)); p0.data = $urandom;
                req0_valid = ($urandom_range(0, 99) < 60); req0_rd = p0.rd; req0_data = p0.data;
            end
            if (!req1_valid || seen1) begin
                p1.rd = REG_AW'($urandom_range(0, 7)); p1.data = $urandom;
                req1_valid = ($urandom_range(0, 99) < 50); req1_rd = p1.rd; req1_data = p1.data;
            end
            iss_valid = $urandom_range(0, 1);
            iss_rd = REG_AW'($urandom_range(0, 7));
            rs1 = REG_AW'($urandom_range(0, 7));
            rs2 = REG_AW'($urandom_range(0, 7));
            @(negedge clk);
            e1 = req1_valid && (!req0_valid || m_starve == MAX_WAIT);
            e0 = req0_valid && !e1;
            es = iss_valid && iss_rd != 0 && m_busy[iss_rd];
            tests++;
            if ({req0_ready, req1_ready} !== {e0, e1}) begin
                failed++; $display("[TB] FAIL rand_grant[%0d]: got %b%b expected %b%b", c, req0_ready, req1_ready, e0, e1);
            end
            tests++;
            if (iss_stall !== es) begin
                failed++; $display("[TB] FAIL rand_stall[%0d]: got %b expected %b", c, iss_stall, es);
            end
            tests++;
            if ({rs1_busy, rs2_busy} !== {m_busy[rs1], m_busy[rs2]}) begin
                failed++; $display("[TB] FAIL rand_rsbusy[%0d]: got %b%b expected %b%b",
                                   c, rs1_busy, rs2_busy, m_busy[rs1], m_busy[rs2]);
            end
            tests++;
            if (write_en !== m_wen || (m_wen && (A3 !== m_a3 || write_data !== m_wdata))) begin
                failed++; $display("[TB] FAIL rand_write[%0d]: we=%b A3=%0d data=%h expected %b/%0d/%h",
                                   c, write_en, A3, write_data, m_wen, m_a3, m_wdata);
            end
            seen0 = req0_ready;
            seen1 = req1_ready;
        end
        tick();
        idle_inputs();
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        test_reset();
        test_single_write();
        test_contention();
        test_x0();
        test_hazards();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
